// File: rtl/rps_match_driver_if.sv
// Signal bundle between the match driver, the player front end and the round evaluator.
// Evaluator handshake: ev_start is held high from acceptance until ev_state=RESULT is seen;
// ev_winner is valid only while ev_state=RESULT; the evaluator ends a round by returning to IDLE.
interface rps_match_driver_if;
   logic       play;
   logic [1:0] player_move;
   logic [2:0] target_wins;
   logic       new_match;
   logic [2:0] ev_state;
   logic [1:0] ev_winner;

   logic       ev_start;
   logic [1:0] ev_p1_move;
   logic [1:0] ev_p2_move;
   logic       busy;
   logic [2:0] p1_score;
   logic [2:0] p2_score;
   logic [3:0] tie_count;
   logic       match_done;
   logic [1:0] match_winner;
   logic       round_done;
   logic       bad_move;
   logic       timeout_err;
   logic       proto_err;

   modport master (
      output play, player_move, target_wins, new_match, ev_state, ev_winner,
      input  ev_start, ev_p1_move, ev_p2_move, busy, p1_score, p2_score, tie_count,
      input  match_done, match_winner, round_done, bad_move, timeout_err, proto_err
   );

   modport slave (
      input  play, player_move, target_wins, new_match, ev_state, ev_winner,
      output ev_start, ev_p1_move, ev_p2_move, busy, p1_score, p2_score, tie_count,
      output match_done, match_winner, round_done, bad_move, timeout_err, proto_err
   );
endinterface

// File: rtl/rps_match_driver.sv
// Rock-paper-scissors match driver: accepts human moves, draws a CPU move from an LFSR,
// runs each round through an external evaluator and keeps score until a target is reached.
module rps_match_driver (
   input  logic                  clk,
   input  logic                  reset,
   rps_match_driver_if.slave     bus,
   output logic [1:0]            state_o,
   output logic [7:0]            lfsr_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LAUNCH  = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [2:0] EV_IDLE   = 3'b000;
   localparam logic [2:0] EV_RESULT = 3'b010;

   localparam logic [1:0] MOVE_BAD  = 2'b11;
   localparam logic [1:0] WIN_TIE   = 2'b00;
   localparam logic [1:0] WIN_P1    = 2'b01;
   localparam logic [1:0] WIN_P2    = 2'b10;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Counter value seen on the 15th cycle after state entry; the error lands on that edge.
   localparam logic [3:0] TMO_LAST  = 4'd14;

   state_t     state_q, state_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic       ev_start_q, ev_start_d;
   logic [1:0] p1_mv_q, p1_mv_d;
   logic [1:0] p2_mv_q, p2_mv_d;
   logic [2:0] p1_score_q, p1_score_d;
   logic [2:0] p2_score_q, p2_score_d;
   logic [3:0] tie_q, tie_d;
   logic       match_done_q, match_done_d;
   logic [1:0] match_winner_q, match_winner_d;
   logic       round_done_q, round_done_d;
   logic       bad_move_q, bad_move_d;
   logic       tmo_err_q, tmo_err_d;
   logic       proto_err_q, proto_err_d;
   logic [3:0] tmo_q, tmo_d;
   logic [2:0] target_q, target_d;

   logic [1:0] cpu_move;
   logic [2:0] target_eff;
   logic       scores_zero;

   assign cpu_move    = (lfsr_q[1:0] == 2'b11) ? 2'b00 : lfsr_q[1:0];
   assign target_eff  = (target_q == 3'd0) ? 3'd1 : target_q;
   assign scores_zero = (p1_score_q == 3'd0) && (p2_score_q == 3'd0) && (tie_q == 4'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         lfsr_q         <= LFSR_SEED;
         ev_start_q     <= 1'b0;
         p1_mv_q        <= 2'b00;
         p2_mv_q        <= 2'b00;
         p1_score_q     <= 3'd0;
         p2_score_q     <= 3'd0;
         tie_q          <= 4'd0;
         match_done_q   <= 1'b0;
         match_winner_q <= 2'b00;
         round_done_q   <= 1'b0;
         bad_move_q     <= 1'b0;
         tmo_err_q      <= 1'b0;
         proto_err_q    <= 1'b0;
         tmo_q          <= 4'd0;
         target_q       <= 3'd0;
      end else begin
         state_q        <= state_d;
         lfsr_q         <= lfsr_d;
         ev_start_q     <= ev_start_d;
         p1_mv_q        <= p1_mv_d;
         p2_mv_q        <= p2_mv_d;
         p1_score_q     <= p1_score_d;
         p2_score_q     <= p2_score_d;
         tie_q          <= tie_d;
         match_done_q   <= match_done_d;
         match_winner_q <= match_winner_d;
         round_done_q   <= round_done_d;
         bad_move_q     <= bad_move_d;
         tmo_err_q      <= tmo_err_d;
         proto_err_q    <= proto_err_d;
         tmo_q          <= tmo_d;
         target_q       <= target_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      lfsr_d         = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      ev_start_d     = ev_start_q;
      p1_mv_d        = p1_mv_q;
      p2_mv_d        = p2_mv_q;
      p1_score_d     = p1_score_q;
      p2_score_d     = p2_score_q;
      tie_d          = tie_q;
      match_done_d   = match_done_q;
      match_winner_d = match_winner_q;
      round_done_d   = 1'b0;
      bad_move_d     = 1'b0;
      tmo_err_d      = tmo_err_q;
      proto_err_d    = proto_err_q;
      tmo_d          = tmo_q;
      target_d       = target_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.new_match) begin
               p1_score_d     = 3'd0;
               p2_score_d     = 3'd0;
               tie_d          = 4'd0;
               match_done_d   = 1'b0;
               match_winner_d = 2'b00;
               tmo_err_d      = 1'b0;
               proto_err_d    = 1'b0;
               tmo_d          = 4'd0;
            end else if (bus.play) begin
               if (bus.player_move == MOVE_BAD) begin
                  bad_move_d = 1'b1;
               end else begin
                  p1_mv_d    = bus.player_move;
                  p2_mv_d    = cpu_move;
                  ev_start_d = 1'b1;
                  tmo_d      = 4'd0;
                  state_d    = ST_LAUNCH;
                  // The target only changes at the first round of a fresh match.
                  if (scores_zero) begin
                     target_d = bus.target_wins;
                  end
               end
            end
         end

         ST_LAUNCH: begin
            tmo_d = tmo_q + 4'd1;
            if (bus.ev_state == EV_RESULT) begin
               case (bus.ev_winner)
                  WIN_TIE: begin
                     if (tie_q != 4'hF) begin
                        tie_d = tie_q + 4'd1;
                     end
                  end
                  WIN_P1:  p1_score_d  = p1_score_q + 3'd1;
                  WIN_P2:  p2_score_d  = p2_score_q + 3'd1;
                  default: proto_err_d = 1'b1;
               endcase
               ev_start_d = 1'b0;
               tmo_d      = 4'd0;
               state_d    = ST_RELEASE;
            end else if (tmo_q == TMO_LAST) begin
               tmo_err_d  = 1'b1;
               ev_start_d = 1'b0;
               tmo_d      = 4'd0;
               state_d    = ST_IDLE;
            end
         end

         ST_RELEASE: begin
            tmo_d = tmo_q + 4'd1;
            if (bus.ev_state == EV_IDLE) begin
               round_done_d = 1'b1;
               tmo_d        = 4'd0;
               if (p1_score_q == target_eff) begin
                  match_done_d   = 1'b1;
                  match_winner_d = WIN_P1;
                  state_d        = ST_DONE;
               end else if (p2_score_q == target_eff) begin
                  match_done_d   = 1'b1;
                  match_winner_d = WIN_P2;
                  state_d        = ST_DONE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (tmo_q == TMO_LAST) begin
               tmo_err_d  = 1'b1;
               ev_start_d = 1'b0;
               tmo_d      = 4'd0;
               state_d    = ST_IDLE;
            end
         end

         ST_DONE: begin
            if (bus.new_match) begin
               p1_score_d     = 3'd0;
               p2_score_d     = 3'd0;
               tie_d          = 4'd0;
               match_done_d   = 1'b0;
               match_winner_d = 2'b00;
               tmo_err_d      = 1'b0;
               proto_err_d    = 1'b0;
               tmo_d          = 4'd0;
               state_d        = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.ev_start     = ev_start_q;
   assign bus.ev_p1_move   = p1_mv_q;
   assign bus.ev_p2_move   = p2_mv_q;
   assign bus.busy         = (state_q == ST_LAUNCH) || (state_q == ST_RELEASE);
   assign bus.p1_score     = p1_score_q;
   assign bus.p2_score     = p2_score_q;
   assign bus.tie_count    = tie_q;
   assign bus.match_done   = match_done_q;
   assign bus.match_winner = match_winner_q;
   assign bus.round_done   = round_done_q;
   assign bus.bad_move     = bad_move_q;
   assign bus.timeout_err  = tmo_err_q;
   assign bus.proto_err    = proto_err_q;

   assign state_o = state_q;
   assign lfsr_o  = lfsr_q;

endmodule
